// File: rtl/ov2640_cfg_pkg.sv
// Shared state types, constants and the SCCB bus-level decode used by the
// OV2640 configuration sequencer and its SCCB write engine.
package ov2640_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE, REWIND, SETTLE, CHECK, WRITE, WAIT_WR, DELAY, STEP, DONE
  } cfg_state_t;

  typedef enum logic [2:0] {
    ENG_IDLE, ENG_START, ENG_DATA, ENG_STOP, ENG_HOLD
  } eng_state_t;

  localparam logic [7:0]  SOFT_RST_REG   = 8'h12;
  localparam logic [15:0] END_CMD        = 16'hFFFF;
  localparam int          SETTLE_CYC     = 2;
  localparam int          BITS_PER_WRITE = 27;
  localparam int          HOLD_SLOTS     = 3;

  // Returns {sioc, siod_oe} for a position in the write; data bit slots run
  // 0..26 as three 9-bit phases (8 data bits MSB first, then a released ack bit).
  function automatic logic [1:0] sccb_level(input eng_state_t st,
                                            input logic [1:0] qtr,
                                            input logic [4:0] bit_idx,
                                            input logic [7:0] dev,
                                            input logic [7:0] ra,
                                            input logic [7:0] dt);
    logic [7:0] byte_v;
    logic [4:0] pos;
    byte_v = dev;
    pos    = bit_idx;
    sccb_level = 2'b10;
    case (st)
      ENG_START: sccb_level = {1'b1, qtr[1]};
      ENG_DATA: begin
        if (bit_idx >= 5'd18) begin
          byte_v = dt;
          pos    = bit_idx - 5'd18;
        end else if (bit_idx >= 5'd9) begin
          byte_v = ra;
          pos    = bit_idx - 5'd9;
        end
        sccb_level = {qtr[1], (pos == 5'd8) ? 1'b0 : ~byte_v[3'd7 - pos[2:0]]};
      end
      ENG_STOP: sccb_level = {qtr[1], qtr != 2'd3};
      default:  sccb_level = 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write engine: start, device address, register, value, stop,
// then a short bus-idle hold before the one-cycle done pulse.
module sccb_write_master
  import ov2640_cfg_pkg::*;
#(
  parameter int         QTR_CYC  = 67,
  parameter logic [7:0] DEV_ADDR = 8'h60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] data,
  output logic       sioc,
  output logic       siod_oe,
  output logic       busy,
  output logic       done
);

  localparam int QW = $clog2(QTR_CYC);

  eng_state_t    state, state_n;
  logic [QW-1:0] tick, tick_n;
  logic [1:0]    qtr, qtr_n;
  logic [4:0]    bit_cnt, bit_n;
  logic [7:0]    reg_q, data_q;
  logic          done_n;

  always_comb begin
    state_n = state;
    tick_n  = tick;
    qtr_n   = qtr;
    bit_n   = bit_cnt;
    done_n  = 1'b0;
    if (state == ENG_IDLE) begin
      if (start) begin
        state_n = ENG_START;
        tick_n  = '0;
        qtr_n   = 2'd0;
        bit_n   = 5'd0;
      end
    end else if (tick == QW'(QTR_CYC - 1)) begin
      tick_n = '0;
      qtr_n  = qtr + 2'd1;
      if (qtr == 2'd3) begin
        case (state)
          ENG_START: state_n = ENG_DATA;
          ENG_DATA: begin
            if (bit_cnt == 5'(BITS_PER_WRITE - 1)) begin
              state_n = ENG_STOP;
              bit_n   = 5'd0;
            end else begin
              bit_n = bit_cnt + 5'd1;
            end
          end
          ENG_STOP: state_n = ENG_HOLD;
          ENG_HOLD: begin
            if (bit_cnt == 5'(HOLD_SLOTS - 1)) begin
              state_n = ENG_IDLE;
              bit_n   = 5'd0;
              done_n  = 1'b1;
            end else begin
              bit_n = bit_cnt + 5'd1;
            end
          end
          default: state_n = ENG_IDLE;
        endcase
      end
    end else begin
      tick_n = tick + 1'b1;
    end
  end

  // Bus pins are registered from the next position so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ENG_IDLE;
      tick    <= '0;
      qtr     <= 2'd0;
      bit_cnt <= 5'd0;
      reg_q   <= 8'h00;
      data_q  <= 8'h00;
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      qtr     <= qtr_n;
      bit_cnt <= bit_n;
      done    <= done_n;
      {sioc, siod_oe} <= sccb_level(state_n, qtr_n, bit_n, DEV_ADDR, reg_q, data_q);
      if (state == ENG_IDLE && start) begin
        reg_q  <= reg_addr;
        data_q <= data;
      end
    end
  end

  assign busy = (state != ENG_IDLE);

endmodule

// File: rtl/ov2640_sccb_config.sv
// Walks the OV2640 register table and writes each entry over SCCB, pausing
// after a soft-reset write; raises done once the end marker is reached.
module ov2640_sccb_config
  import ov2640_cfg_pkg::*;
#(
  parameter int         CLK_HZ        = 27_000_000,
  parameter int         SCCB_HZ       = 100_000,
  parameter int         QTR_CYC       = CLK_HZ / (4 * SCCB_HZ),
  parameter logic [7:0] DEV_ADDR      = 8'h60,
  parameter int         RST_DELAY_CYC = CLK_HZ / 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        resend,
  output logic        advance,
  output logic        sioc,
  output logic        siod_oe,
  output logic        busy,
  output logic        done
);

  localparam int DW = $clog2(RST_DELAY_CYC + 1);

  cfg_state_t    state, state_n;
  logic [DW-1:0] cnt;
  logic [15:0]   cmd_q;
  logic          eng_start, eng_busy, eng_done, fsm_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cmd_q <= 16'h0000;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if (state == SETTLE || state == DELAY)
        cnt <= cnt + 1'b1;
      if (state == CHECK)
        cmd_q <= command;
    end
  end

  // One counter serves both the table settle wait and the soft-reset pause.
  always_comb begin
    state_n   = state;
    resend    = 1'b0;
    advance   = 1'b0;
    done      = 1'b0;
    fsm_busy  = 1'b1;
    eng_start = 1'b0;
    case (state)
      IDLE: begin
        fsm_busy = 1'b0;
        if (start) state_n = REWIND;
      end
      REWIND: begin
        resend  = 1'b1;
        state_n = SETTLE;
      end
      SETTLE:  if (cnt == DW'(SETTLE_CYC - 1)) state_n = CHECK;
      CHECK:   state_n = (finished || command == END_CMD) ? DONE : WRITE;
      WRITE: begin
        eng_start = 1'b1;
        state_n   = WAIT_WR;
      end
      WAIT_WR: begin
        if (eng_done)
          state_n = (cmd_q[15:8] == SOFT_RST_REG && cmd_q[7]) ? DELAY : STEP;
      end
      DELAY:   if (cnt == DW'(RST_DELAY_CYC - 1)) state_n = STEP;
      STEP: begin
        advance = 1'b1;
        state_n = SETTLE;
      end
      DONE: begin
        fsm_busy = 1'b0;
        done     = 1'b1;
        if (start) state_n = REWIND;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = fsm_busy | eng_busy;

  sccb_write_master #(
    .QTR_CYC  (QTR_CYC),
    .DEV_ADDR (DEV_ADDR)
  ) u_sccb (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .reg_addr (cmd_q[15:8]),
    .data     (cmd_q[7:0]),
    .sioc     (sioc),
    .siod_oe  (siod_oe),
    .busy     (eng_busy),
    .done     (eng_done)
  );

endmodule

// File: tb/tb_ov2640_sccb_config.sv
// Directed bench: registered table model plus an SCCB bus decoder sampling on
// the falling clock edge, with hand-computed expected bytes and timings.
module tb_ov2640_sccb_config;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] command = 16'h0000;
  logic        finished, resend, advance, sioc, siod_oe, busy, done;

  logic [15:0] tbl [4];
  logic [1:0]  tbl_idx = 2'd0;

  int err_count = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  ov2640_sccb_config #(
    .CLK_HZ        (27_000_000),
    .SCCB_HZ       (100_000),
    .QTR_CYC       (2),
    .DEV_ADDR      (8'h60),
    .RST_DELAY_CYC (50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .command  (command),
    .finished (finished),
    .resend   (resend),
    .advance  (advance),
    .sioc     (sioc),
    .siod_oe  (siod_oe),
    .busy     (busy),
    .done     (done)
  );

  // Table with two clocks of latency from resend/advance to command.
  always @(posedge clk) begin
    if (resend)       tbl_idx <= 2'd0;
    else if (advance) tbl_idx <= tbl_idx + 2'd1;
    command <= tbl[tbl_idx];
  end
  assign finished = (command == 16'hFFFF);

  // Bus decoder state.
  logic       sioc_p = 1'b1;
  logic       siod_p = 1'b1;
  logic       siod;
  logic       in_xfer = 1'b0;
  logic [7:0] shift_r = 8'h00;
  logic [7:0] cap [$];
  int bits = 0, cyc = 0, n_start = 0, n_stop = 0, n_rise = 0, n_tog = 0;
  int hs_viol = 0, n_resend = 0, n_adv = 0, n_overlap = 0;
  int per_min = 1000, per_max = 0, last_rise = -1, start_cyc = 0, stop_cyc = -1;
  int gaps [$];
  int wins [$];

  always @(negedge clk) begin
    cyc++;
    siod = ~siod_oe;
    if (rst) begin
      in_xfer = 1'b0;
      bits    = 0;
    end else begin
      if (resend) n_resend++;
      if (advance) n_adv++;
      if (resend && advance) n_overlap++;
      if (sioc != sioc_p) n_tog++;
      if (sioc_p && sioc && siod != siod_p) begin
        if (!siod && !in_xfer) begin
          in_xfer = 1'b1;
          bits = 0;
          n_start++;
          if (stop_cyc >= 0) gaps.push_back(cyc - stop_cyc);
          start_cyc = cyc;
          last_rise = -1;
        end else if (siod && in_xfer && bits == 28) begin
          in_xfer = 1'b0;
          n_stop++;
          stop_cyc = cyc;
          wins.push_back(cyc - start_cyc);
        end else begin
          hs_viol++;
        end
      end
      if (!sioc_p && sioc) begin
        n_rise++;
        if (in_xfer) begin
          if (last_rise >= 0) begin
            if (cyc - last_rise < per_min) per_min = cyc - last_rise;
            if (cyc - last_rise > per_max) per_max = cyc - last_rise;
          end
          last_rise = cyc;
          bits++;
          shift_r = {shift_r[6:0], siod};
          if (bits == 8 || bits == 17 || bits == 26) cap.push_back(shift_r);
        end
      end
    end
    sioc_p = sioc;
    siod_p = siod;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clearMonitor();
    cap.delete();
    gaps.delete();
    wins.delete();
    n_start = 0; n_stop = 0; n_rise = 0; n_tog = 0; hs_viol = 0;
    n_resend = 0; n_adv = 0; n_overlap = 0;
    per_min = 1000; per_max = 0; stop_cyc = -1;
  endtask

  task automatic loadTable(input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
  endtask

  task automatic waitDone(input int max_cyc, output int n);
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Full pass over {FF_01, 12_80, 11_80, FFFF}.
  task automatic checkFullRun(input string run);
    logic [7:0] exp_bytes [9];
    exp_bytes = '{8'h60, 8'hFF, 8'h01, 8'h60, 8'h12, 8'h80, 8'h60, 8'h11, 8'h80};
    checkOutput({run, "_nbytes"}, cap.size(), 9);
    for (int i = 0; i < 9; i++)
      checkOutput($sformatf("%s_byte%0d", run, i),
                  (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD, 32'(exp_bytes[i]));
    checkOutput({run, "_starts"}, n_start, 3);
    checkOutput({run, "_stops"}, n_stop, 3);
    checkOutput({run, "_resends"}, n_resend, 1);
    checkOutput({run, "_advances"}, n_adv, 3);
    checkOutput({run, "_overlap"}, n_overlap, 0);
    checkOutput({run, "_hi_changes"}, hs_viol, 0);
    checkOutput({run, "_sioc_per_min"}, per_min, 8);
    checkOutput({run, "_sioc_per_max"}, per_max, 8);
    checkOutput({run, "_sioc_rises"}, n_rise, 84);
    // Start fall at quarter 2 of the start slot, stop release at quarter 3 of
    // slot 28: 113 quarters of 2 clocks.
    checkOutput({run, "_start_to_stop"}, (wins.size() > 0) ? wins[0] : -1, 226);
    checkOutput({run, "_gap_normal_lt50"}, (gaps.size() > 0) && (gaps[0] < 50), 1);
    checkOutput({run, "_gap_softrst_ge50"}, (gaps.size() > 1) && (gaps[1] >= 50), 1);
    checkOutput({run, "_done"}, done, 1);
    checkOutput({run, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int n;
    int bad;
    loadTable(16'hFF01, 16'h1280, 16'h1180, 16'hFFFF);
    repeat (4) @(negedge clk);
    checkOutput("rst_sioc", sioc, 1);
    checkOutput("rst_siod_oe", siod_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_resend", resend, 0);
    checkOutput("rst_advance", advance, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clearMonitor();

    $display("[TB] full table run");
    applyStimulus();
    checkOutput("run1_resend_now", resend, 1);
    checkOutput("run1_busy_now", busy, 1);
    checkOutput("run1_done_now", done, 0);
    repeat (100) @(negedge clk);
    applyStimulus();
    waitDone(5000, n);
    repeat (2) @(negedge clk);
    checkFullRun("run1");

    $display("[TB] restart after done");
    clearMonitor();
    applyStimulus();
    checkOutput("run2_resend_now", resend, 1);
    checkOutput("run2_busy_now", busy, 1);
    checkOutput("run2_done_now", done, 0);
    waitDone(5000, n);
    repeat (2) @(negedge clk);
    checkFullRun("run2");

    $display("[TB] empty table");
    loadTable(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    clearMonitor();
    applyStimulus();
    waitDone(50, n);
    checkOutput("empty_done_within5", (n + 1) <= 5, 1);
    checkOutput("empty_done", done, 1);
    repeat (5) @(negedge clk);
    checkOutput("empty_sioc_toggles", n_tog, 0);
    checkOutput("empty_advances", n_adv, 0);

    $display("[TB] reset during second byte");
    loadTable(16'hFF01, 16'h1280, 16'h1180, 16'hFFFF);
    clearMonitor();
    applyStimulus();
    n = 0;
    while (!(n_start == 2 && bits == 9 && sioc == 1'b0 && siod_oe == 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_window_found", n < 3000, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_sioc", sioc, 1);
    checkOutput("midrst_siod_oe", siod_oe, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sioc !== 1'b1 || siod_oe !== 1'b0) bad++;
    end
    checkOutput("midrst_bus_idle", bad, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clearMonitor();
    applyStimulus();
    waitDone(5000, n);
    repeat (2) @(negedge clk);
    checkFullRun("run3");

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/ov2640_sccb_config.md
Name: ov2640_sccb_config

Overview:
- Sequences the OV2640 configuration register table and writes each entry to the camera over SCCB (3-phase write).
- Walks the table by pulsing its resend/advance inputs and reads its 16-bit command output as {register[15:8], value[7:0]}.
- Stops when the table's finished flag is set (end marker 16'hFFFF).
- Sits between the register table and the camera SIOC/SIOD pins; raises done so the capture path can come out of hold.

Parameters:
- CLK_HZ, 27_000_000, system clock frequency.
- SCCB_HZ, 100_000, SIOC frequency.
- QTR_CYC, CLK_HZ/(4*SCCB_HZ), clocks per quarter SCCB bit period; minimum 2.
- DEV_ADDR, 8'h60, OV2640 SCCB write address.
- RST_DELAY_CYC, CLK_HZ/1000, wait after a soft-reset write (1 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins or restarts configuration.
- command  in  16  table output {reg, value}; registered, valid 2 clocks after resend/advance.
- finished  in  1  table end flag (command == 16'hFFFF).
- resend  out  1  one-cycle pulse; rewinds table to entry 0.
- advance  out  1  one-cycle pulse; steps table to the next entry.
- sioc  out  1  SCCB clock; push-pull, idle 1.
- siod_oe  out  1  1 = drive SIOD low, 0 = release (external pull-up).
- busy  out  1  configuration in progress.
- done  out  1  configuration complete; held until next start or rst.

Behaviour:
- Reset values (async on rst): sioc=1, siod_oe=0, resend=0, advance=0, busy=0, done=0. State=IDLE and all counters 0.
- rst mid-transaction abandons the transaction immediately. No stop condition is generated.
- FSM states: IDLE, REWIND, SETTLE, CHECK, WRITE, WAIT_WR, DELAY, STEP, DONE.
- IDLE/DONE + start:
  - Pulse resend for 1 cycle, then enter SETTLE.
  - Set busy=1 and done=0 in the same cycle resend is asserted.
- SETTLE: wait exactly 2 clocks to cover the table's address→command latency, then go to CHECK.
- CHECK:
  - finished=1 → DONE (busy=0, done=1).
  - Otherwise latch command and go to WRITE.
- WRITE: issue a 1-cycle start to the SCCB write engine, then go to WAIT_WR.
- WAIT_WR: on engine done:
  - If latched reg==8'h12 and value[7]==1 (soft reset) → DELAY.
  - Otherwise → STEP.
- DELAY: count RST_DELAY_CYC clocks with sioc=1 and siod_oe=0, then go to STEP.
- STEP: pulse advance for 1 cycle, then go to SETTLE.
- Every table entry except the end marker produces exactly one SCCB write. This includes bank-select entries (reg 8'hFF) and duplicate entries.
- start while busy is ignored.
- start in DONE restarts from entry 0 via resend.
- resend and advance are never asserted in the same cycle.
- SCCB write engine:
  - Start condition: SIOD falls while SIOC is high. Hold QTR_CYC before and after.
  - Then 3 phases: DEV_ADDR, reg, value. Each phase is 8 data bits MSB-first plus a 9th don't-care bit with SIOD released.
  - The ack bit is not sampled.
  - Each bit is 4 quarters:
    - Q0: SIOC low, SIOD changes.
    - Q1: SIOC low.
    - Q2: SIOC high.
    - Q3: SIOC high.
  - Stop condition: SIOD low with SIOC rising, then SIOD released while SIOC is high.
  - After the stop, hold ≥ 2 quarters of bus idle before signalling done.
  - Total write time = (1 + 27 + 2 + 2) × 4 × QTR_CYC clocks (≈ 320 µs at defaults).
  - siod_oe = ~bit whenever data is driven, so 0 bits pull SIOD low.
- Counters:
  - Quarter counter: $clog2(QTR_CYC) bits, wraps at QTR_CYC-1.
  - Bit counter: 0..26 across the 3 phases.
  - Delay counter: $clog2(RST_DELAY_CYC+1) bits.

Decomposition:
- Package ov2640_cfg_pkg:
  - FSM state enum.
  - SOFT_RST_REG = 8'h12.
  - END_CMD = 16'hFFFF.
  - SETTLE_CYC = 2.
  - BITS_PER_WRITE = 27.
- Sub-module sccb_write_master:
  - Parameters: QTR_CYC, DEV_ADDR.
  - Ports: clk, rst, start, reg_addr[7:0], data[7:0], sioc, siod_oe, busy, done (1-cycle pulse).
- The top level contains only the sequencing FSM and the delay counter.

Test Plan:
- Reset: assert rst mid-simulation → sioc=1, siod_oe=0, busy=0, done=0 within the same cycle, no clock edge required.
- Table model {FF_01, 12_80, 11_80, FFFF}, QTR_CYC=2, RST_DELAY_CYC=50, start pulse:
  - SCCB decoder captures exactly 60/FF/01, 60/12/80, 60/11/80.
  - 1 resend and 3 advance pulses observed.
  - ≥50 idle clocks between the 2nd stop and the 3rd start.
  - done=1 afterwards.
- Bit timing with QTR_CYC=2:
  - SIOC period is 8 clocks.
  - SIOD changes only while SIOC is low, except at start/stop conditions.
  - One write lasts 256 clocks.
- Table model {FFFF} → no SIOC toggle, 0 advance pulses, done=1 within 5 clocks of start.
- Second start while busy → ignored (no extra resend).
- Second start after done → resend pulse, done=0 and busy=1, full sequence repeats identically.
- rst asserted during the 2nd byte of a write, then released, then start → bus idle during reset; new sequence begins from entry 0 with a clean start condition.
